// File: rtl/prefetch_queue_pkg.sv
// +-----------------------------------------------------------------------+
// | prefetch_queue_pkg : shared reset CS:IP and physical address helpers  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package prefetch_queue_pkg;

    localparam int          PADDR_W  = 20;
    localparam logic [15:0] RESET_CS = 16'hF000;
    localparam logic [15:0] RESET_IP = 16'hFFF0;

    // Segment*16 + offset; the carry out of bit 19 is dropped so the sum wraps to low memory.
    function automatic logic [PADDR_W-1:0] phys_addr(input logic [15:0] cs, input logic [15:0] ip);
        return {cs, 4'b0000} + {4'b0000, ip};
    endfunction

endpackage

`default_nettype wire

// File: rtl/prefetch_queue_ring.sv
// +-----------------------------------------------------------------------+
// | pf_ring : DEPTH x 8 byte ring buffer with head/tail pointers and count|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module pf_ring #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    store [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          pop_ok;

    assign valid  = (count != '0);
    assign pop_ok = pop && valid;
    // Force a clean zero while empty so the head byte never exposes stale storage.
    assign data   = valid ? store[head] : 8'h00;

    always_ff @(posedge clock) begin
        if (push) begin
            store[tail] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop_ok) begin
                head <= head + AW'(1);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/prefetch_queue.sv
// +-----------------------------------------------------------------------+
// | prefetch_queue : byte-wide code prefetch queue fetching at CS:IP      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic [15:0]        flush_cs,
    input  logic [15:0]        flush_ip,
    output logic [7:0]         q_byte,
    output logic [15:0]        q_ip,
    output logic               q_valid,
    input  logic               q_ready,
    input  logic               bus_busy,
    output logic               mem_req,
    output logic [PADDR_W-1:0] mem_address,
    input  logic [7:0]         mem_data
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]   fcs;
    logic [15:0]   fip;
    logic          inflight;
    logic [CW-1:0] count;
    logic [CW-1:0] pending;
    logic          push;
    logic          pop;

    // Reserve a slot for the read still on the bus so the ring can never overflow.
    assign pending     = count + CW'(inflight);
    assign mem_req     = !reset && !flush && !bus_busy && (pending < CW'(DEPTH));
    assign mem_address = phys_addr(fcs, fip);

    // A flush cancels the read issued last cycle: its returning byte is simply not pushed.
    assign push = inflight && !flush && !reset;
    assign pop  = q_valid && q_ready && !flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            fcs      <= RESET_CS;
            fip      <= RESET_IP;
            q_ip     <= RESET_IP;
            inflight <= 1'b0;
        end else if (flush) begin
            fcs      <= flush_cs;
            fip      <= flush_ip;
            q_ip     <= flush_ip;
            inflight <= 1'b0;
        end else begin
            inflight <= mem_req;
            if (mem_req) begin
                fip <= fip + 16'd1;
            end
            if (pop) begin
                q_ip <= q_ip + 16'd1;
            end
        end
    end

    pf_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clock     (clock),
        .reset     (reset),
        .clear     (flush),
        .push      (push),
        .push_data (mem_data),
        .pop       (pop),
        .data      (q_byte),
        .valid     (q_valid),
        .count     (count)
    );

endmodule

`default_nettype wire

// File: tb/tb_prefetch_queue.sv
// +-----------------------------------------------------------------------+
// | tb_prefetch_queue : directed vectors plus randomized model checking   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_prefetch_queue;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] flush_cs = 16'h0;
    logic [15:0] flush_ip = 16'h0;
    logic [7:0]  q_byte;
    logic [15:0] q_ip;
    logic        q_valid;
    logic        q_ready = 1'b0;
    logic        bus_busy = 1'b0;
    logic        mem_req;
    logic [19:0] mem_address;
    logic [7:0]  mem_data = 8'h00;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    prefetch_queue #(.DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .flush_cs    (flush_cs),
        .flush_ip    (flush_ip),
        .q_byte      (q_byte),
        .q_ip        (q_ip),
        .q_valid     (q_valid),
        .q_ready     (q_ready),
        .bus_busy    (bus_busy),
        .mem_req     (mem_req),
        .mem_address (mem_address),
        .mem_data    (mem_data)
    );

    function automatic logic [7:0] memf(input logic [19:0] a);
        logic [7:0] t;
        case (a)
            20'hFFFF0: return 8'hEA;
            20'hFFFF1: return 8'h00;
            20'hFFFF2: return 8'h01;
            20'hFFFF3: return 8'hF0;
            default: begin
                t = a[7:0] * 8'd29;
                return t ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h5A;
            end
        endcase
    endfunction

    function automatic logic [19:0] tb_phys(input logic [15:0] cs, input logic [15:0] ip);
        int unsigned s;
        s = (int'(cs) * 16 + int'(ip)) % (1 << 20);
        return s[19:0];
    endfunction

    // Memory answers one cycle after a request; otherwise it returns junk.
    always @(posedge clock) begin
        if (mem_req) mem_data <= memf(mem_address);
        else         mem_data <= 8'($urandom);
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    // Reference: everything issued since the last flush/reset is either in flight or queued,
    // and the core must see bytes at consecutive IPs from the restart point.
    bit          model_on = 1'b0;
    bit          m_synced = 1'b0;
    int          m_issued, m_popped, m_last;
    logic [15:0] m_cs, m_fip, m_qip;

    always @(negedge clock) begin : model
        bit exp_req;
        bit exp_valid;
        if (model_on) begin
            exp_req   = !reset && !flush && !bus_busy && ((m_issued - m_popped) < DEPTH);
            exp_valid = (m_issued - m_last - m_popped) > 0;
            if (m_synced) begin
                check_eq("m_req", 32'(mem_req), 32'(exp_req));
                if (exp_req && mem_req)
                    check_eq("m_addr", 32'(mem_address), 32'(tb_phys(m_cs, m_fip)));
                check_eq("m_valid", 32'(q_valid), 32'(exp_valid));
                if (exp_valid && q_valid) begin
                    check_eq("m_qip", 32'(q_ip), 32'(m_qip));
                    check_eq("m_byte", 32'(q_byte), 32'(memf(tb_phys(m_cs, m_qip))));
                end
            end
            if (reset) begin
                m_synced = 1'b1;
                m_issued = 0; m_popped = 0; m_last = 0;
                m_cs = 16'hF000; m_fip = 16'hFFF0; m_qip = 16'hFFF0;
            end else if (m_synced) begin
                if (flush) begin
                    m_issued = 0; m_popped = 0; m_last = 0;
                    m_cs = flush_cs; m_fip = flush_ip; m_qip = flush_ip;
                end else begin
                    if (exp_valid && q_ready) begin
                        m_popped++;
                        m_qip++;
                    end
                    if (exp_req) begin
                        m_issued++;
                        m_fip++;
                    end
                    m_last = exp_req ? 1 : 0;
                end
            end
        end
    end

    typedef struct {
        bit          rst;
        bit          fl;
        logic [15:0] cs;
        logic [15:0] ip;
        bit          busy;
        bit          rdy;
        bit          chk_state;
        bit          full;
        bit          e_req;
        logic [19:0] e_addr;
        bit          e_valid;
        logic [15:0] e_ip;
        logic [7:0]  e_byte;
    } vec_t;

    function automatic vec_t mk(bit rst, bit fl, logic [15:0] cs, logic [15:0] ip, bit busy, bit rdy,
                                bit chk_state, bit full, bit e_req, logic [19:0] e_addr,
                                bit e_valid, logic [15:0] e_ip, logic [7:0] e_byte);
        vec_t v;
        v.rst = rst; v.fl = fl; v.cs = cs; v.ip = ip; v.busy = busy; v.rdy = rdy;
        v.chk_state = chk_state; v.full = full; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_ip = e_ip; v.e_byte = e_byte;
        return v;
    endfunction

    vec_t        vt[13];
    int          nreq;
    logic [19:0] addrs[$];
    logic [15:0] ips[$];

    initial begin
        vt[0]  = mk(1, 0, 16'h0, 16'h0, 0, 1, 0, 0, 0, 20'h0,     0, 16'h0,    8'h00);
        vt[1]  = mk(1, 0, 16'h0, 16'h0, 0, 1, 1, 1, 0, 20'hFFFF0, 0, 16'hFFF0, 8'h00);
        vt[2]  = mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 1, 1, 20'hFFFF0, 0, 16'hFFF0, 8'h00);
        vt[3]  = mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 0, 1, 20'hFFFF1, 0, 16'h0,    8'h00);
        vt[4]  = mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 0, 1, 20'hFFFF2, 1, 16'hFFF0, 8'hEA);
        vt[5]  = mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 0, 1, 20'hFFFF3, 1, 16'hFFF1, 8'h00);
        vt[6]  = mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 0, 1, 20'hFFFF4, 1, 16'hFFF2, 8'h01);
        vt[7]  = mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 0, 1, 20'hFFFF5, 1, 16'hFFF3, 8'hF0);
        vt[8]  = mk(0, 1, 16'h1234, 16'h0010, 0, 1, 1, 0, 0, 20'h0, 1, 16'hFFF4, memf(20'hFFFF4));
        vt[9]  = mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 1, 1, 20'h12350, 0, 16'h0010, 8'h00);
        vt[10] = mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 0, 1, 20'h12351, 0, 16'h0,    8'h00);
        vt[11] = mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 0, 1, 20'h12352, 1, 16'h0010, memf(20'h12350));
        vt[12] = mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 0, 1, 20'h12353, 1, 16'h0011, memf(20'h12351));

        @(posedge clock);
        #1;
        for (int i = 0; i < 13; i++) begin
            reset = vt[i].rst; flush = vt[i].fl; flush_cs = vt[i].cs; flush_ip = vt[i].ip;
            bus_busy = vt[i].busy; q_ready = vt[i].rdy;
            @(negedge clock);
            check_eq($sformatf("v%0d_req", i), 32'(mem_req), 32'(vt[i].e_req));
            if (vt[i].e_req || vt[i].full)
                check_eq($sformatf("v%0d_addr", i), 32'(mem_address), 32'(vt[i].e_addr));
            if (vt[i].chk_state)
                check_eq($sformatf("v%0d_valid", i), 32'(q_valid), 32'(vt[i].e_valid));
            if (vt[i].e_valid || vt[i].full)
                check_eq($sformatf("v%0d_qip", i), 32'(q_ip), 32'(vt[i].e_ip));
            if (vt[i].e_valid || (vt[i].rst && vt[i].chk_state))
                check_eq($sformatf("v%0d_byte", i), 32'(q_byte), 32'(vt[i].e_byte));
            @(posedge clock);
            #1;
        end

        // Fill to capacity with no consumer, then release exactly one slot.
        model_on = 1'b1;
        flush = 1'b0; bus_busy = 1'b0; q_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        nreq = 0;
        repeat (20) begin
            @(negedge clock);
            if (mem_req) nreq++;
            @(posedge clock);
            #1;
        end
        check_eq("full_req_count", 32'(nreq), 32'd8);
        q_ready = 1'b1;
        @(negedge clock);
        check_eq("full_valid", 32'(q_valid), 32'd1);
        @(posedge clock);
        #1;
        q_ready = 1'b0;
        nreq = 0;
        repeat (8) begin
            @(negedge clock);
            if (mem_req) nreq++;
            @(posedge clock);
            #1;
        end
        check_eq("pop_one_req", 32'(nreq), 32'd1);

        // bus_busy pulse during streaming.
        reset = 1'b1;
        step();
        reset = 1'b0;
        q_ready = 1'b1;
        repeat (6) step();
        bus_busy = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check_eq("busy_no_req", 32'(mem_req), 32'd0);
            @(posedge clock);
            #1;
        end
        bus_busy = 1'b0;
        repeat (10) step();

        // Offset wrap within the segment.
        flush = 1'b1; flush_cs = 16'hF000; flush_ip = 16'hFFFE;
        step();
        flush = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (mem_req) addrs.push_back(mem_address);
            if (q_valid && q_ready) ips.push_back(q_ip);
            @(posedge clock);
            #1;
        end
        check_eq("wrap_nreq_ge3", 32'(addrs.size() >= 3), 32'd1);
        check_eq("wrap_nip_ge3", 32'(ips.size() >= 3), 32'd1);
        if (addrs.size() >= 3) begin
            check_eq("wrap_addr0", 32'(addrs[0]), 32'h0FFFFE);
            check_eq("wrap_addr1", 32'(addrs[1]), 32'h0FFFFF);
            check_eq("wrap_addr2", 32'(addrs[2]), 32'h0F0000);
        end
        if (ips.size() >= 3) begin
            check_eq("wrap_ip0", 32'(ips[0]), 32'h0FFFE);
            check_eq("wrap_ip1", 32'(ips[1]), 32'h0FFFF);
            check_eq("wrap_ip2", 32'(ips[2]), 32'h00000);
        end

        // Physical sum above 20'hFFFFF wraps to low memory.
        flush = 1'b1; flush_cs = 16'hFFFF; flush_ip = 16'h0020;
        step();
        flush = 1'b0;
        @(negedge clock);
        check_eq("phys_wrap_req", 32'(mem_req), 32'd1);
        check_eq("phys_wrap_addr", 32'(mem_address), 32'h00010);
        @(posedge clock);
        #1;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 4000; n++) begin
            reset    = ($urandom_range(0, 199) == 0);
            flush    = ($urandom_range(0, 49) == 0);
            flush_cs = 16'($urandom);
            flush_ip = ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom);
            bus_busy = ($urandom_range(0, 9) < 3);
            q_ready  = ($urandom_range(0, 9) < 6);
            step();
        end
        reset = 1'b0; flush = 1'b0; bus_busy = 1'b0; q_ready = 1'b1;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
